// File: rtl/instr_prefetch.sv
// Instruction prefetch front end for the stack-machine core.
// Streams sequential words from a 1-cycle-latency ROM into a small FIFO and
// hands them to the core on a valid/ready handshake, each tagged with its PC.
// A redirect (JMP) flushes the FIFO and any in-flight read, then restarts
// fetching at the target PC.
module instr_prefetch #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    output logic [ADDR_W-1:0]         address_rom,
    input  logic [DATA_W-1:0]         q_rom,
    output logic                      word_valid,
    output logic [DATA_W-1:0]         word_data,
    output logic [ADDR_W-1:0]         word_pc,
    input  logic                      word_ready,
    input  logic                      redirect_valid,
    input  logic [ADDR_W-1:0]         redirect_pc,
    output logic [$clog2(DEPTH):0]    fifo_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Occupancy limit including the in-flight read (one bit wider than count
    // so count + inflight never overflows the comparison).
    localparam logic [CNT_W:0]   OCC_MAX  = (CNT_W+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Fetch side state
    logic [ADDR_W-1:0] fetch_pc;
    logic              inflight;
    logic [ADDR_W-1:0] inflight_pc;
    logic              inflight_epoch;
    logic              epoch;

    // FIFO storage and control
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;

    logic [CNT_W:0]    occupancy;
    logic              issue;
    logic              push;
    logic              pop;

    // Issue/capture/pop decisions; redirect overrides all three.
    // Issue counts the in-flight read against capacity and takes no credit
    // for a same-cycle pop, so the FIFO can never be pushed while full.
    always_comb begin
        occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        issue     = !redirect_valid && (occupancy < OCC_MAX);
        push      = inflight && (inflight_epoch == epoch) && !redirect_valid;
        pop       = word_valid && word_ready && !redirect_valid;
    end

    // Fetch PC, in-flight tracking and epoch.
    // A redirect clears inflight outright; the epoch tag is a second guard
    // so that a ROM return belonging to the old stream can never be captured.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            fetch_pc       <= '0;
            inflight       <= 1'b0;
            inflight_pc    <= '0;
            inflight_epoch <= 1'b0;
            epoch          <= 1'b0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            epoch    <= ~epoch;
        end else if (issue) begin
            fetch_pc       <= fetch_pc + ADDR_W'(1);
            inflight       <= 1'b1;
            inflight_pc    <= fetch_pc;
            inflight_epoch <= epoch;
        end else begin
            inflight <= 1'b0;
        end
    end

    // FIFO pointers and occupancy; a redirect empties the FIFO regardless of
    // any push or pop in the same cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage write; contents need no reset since count gates validity.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr] <= q_rom;
            pc_mem[wr_ptr]   <= inflight_pc;
        end
    end

    assign address_rom = fetch_pc;
    assign word_valid  = (count != '0);
    assign word_data   = data_mem[rd_ptr];
    assign word_pc     = pc_mem[rd_ptr];
    assign fifo_count  = count;

    // The issue throttle must make a push into a full FIFO impossible.
    a_no_overflow : assert property (
        @(posedge clock) disable iff (!reset_n)
        !(push && (count == CNT_FULL))
    ) else $error("instr_prefetch: push into full FIFO");

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch. Stimulus pushes the expected words into a
// scoreboard queue; a separate monitor pops and compares on every handshake.
module tb_instr_prefetch;

    logic        clock;
    logic        reset_n;
    logic [15:0] address_rom;
    logic [15:0] q_rom;
    logic        word_valid;
    logic [15:0] word_data;
    logic [15:0] word_pc;
    logic        word_ready;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic [2:0]  fifo_count;

    instr_prefetch #(.DATA_W(16), .ADDR_W(16), .DEPTH(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .address_rom    (address_rom),
        .q_rom          (q_rom),
        .word_valid     (word_valid),
        .word_data      (word_data),
        .word_pc        (word_pc),
        .word_ready     (word_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fifo_count     (fifo_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM model: ROM[i] = 0x1000 + i, one cycle read latency
    always @(posedge clock) q_rom <= 16'h1000 + address_rom;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
        end
    endtask

    task automatic push_exp(input logic [15:0] pc);
        exp_t e;
        e.pc   = pc;
        e.data = 16'h1000 + pc;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        cyc++;
    endtask

    task automatic at_mid();
        @(negedge clock);
    endtask

    // Hold reset across one negedge, check reset state, release just after a
    // rising edge so the following cycle is cycle 0.
    task automatic do_reset();
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        at_mid();
        #1;
        chk("rst_valid", 32'(word_valid), 32'd0);
        chk("rst_count", 32'(fifo_count), 32'd0);
        chk("rst_addr",  32'(address_rom), 32'd0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        cyc     = 0;
    endtask

    // Monitor: pops the scoreboard on every accepted word and checks that the
    // head stays stable while stalled.
    logic        hold_chk = 1'b0;
    logic [15:0] held_pc;
    logic [15:0] held_data;
    always @(negedge clock) begin
        if (reset_n) begin
            if (hold_chk && word_valid) begin
                chk("stall_pc",   32'(word_pc),   32'(held_pc));
                chk("stall_data", 32'(word_data), 32'(held_data));
            end
            if (word_valid && word_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_word: got pc %0h data %0h, expected none (cycle %0d)",
                             word_pc, word_data, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("word_pc",   32'(word_pc),   32'(e.pc));
                    chk("word_data", 32'(word_data), 32'(e.data));
                end
            end
            hold_chk  = word_valid && !word_ready && !redirect_valid;
            held_pc   = word_pc;
            held_data = word_data;
        end else begin
            hold_chk = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        reset_n        = 1'b0;
        word_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Streaming from reset
        word_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 10; i++) push_exp(16'(i));
        while (cyc < 12) begin
            at_mid();
            chk("p1_addr",  32'(address_rom), 32'(cyc));
            chk("p1_valid", 32'(word_valid),  32'(cyc >= 2));
            tick();
        end
        word_ready = 1'b0;
        chk("p1_drained", 32'(exp_q.size()), 32'd0);

        // Backpressure: saturate at 4, then release
        word_ready = 1'b0;
        do_reset();
        while (cyc < 9) begin
            at_mid();
            if (cyc >= 6) begin
                chk("p2_count", 32'(fifo_count),  32'd4);
                chk("p2_addr",  32'(address_rom), 32'd4);
                chk("p2_pc",    32'(word_pc),     32'd0);
                chk("p2_data",  32'(word_data),   32'h1000);
            end
            tick();
        end
        for (int i = 0; i < 10; i++) push_exp(16'(i));
        word_ready = 1'b1;
        while (cyc < 19) begin
            at_mid();
            chk("p2_valid", 32'(word_valid), 32'd1);
            tick();
        end
        word_ready = 1'b0;
        chk("p2_drained", 32'(exp_q.size()), 32'd0);

        // Single redirect to 0x0040 at cycle 10
        word_ready = 1'b1;
        do_reset();
        for (int i = 0; i <= 8; i++) push_exp(16'(i));
        for (int i = 0; i < 6; i++) push_exp(16'h0040 + 16'(i));
        while (cyc < 19) begin
            redirect_valid = (cyc == 10);
            redirect_pc    = 16'h0040;
            at_mid();
            if (cyc == 11 || cyc == 12) chk("p3_gap", 32'(word_valid), 32'd0);
            if (cyc == 11) chk("p3_addr", 32'(address_rom), 32'h0040);
            if (cyc == 13) chk("p3_first", 32'(word_valid), 32'd1);
            tick();
        end
        redirect_valid = 1'b0;
        word_ready     = 1'b0;
        chk("p3_drained", 32'(exp_q.size()), 32'd0);

        // Back-to-back redirects 0x0010 then 0x0020 at cycles 5 and 6
        word_ready = 1'b1;
        do_reset();
        for (int i = 0; i <= 3; i++) push_exp(16'(i));
        for (int i = 0; i < 5; i++) push_exp(16'h0020 + 16'(i));
        while (cyc < 14) begin
            redirect_valid = (cyc == 5) || (cyc == 6);
            redirect_pc    = (cyc == 5) ? 16'h0010 : 16'h0020;
            at_mid();
            if (cyc >= 6 && cyc <= 8) chk("p4_gap", 32'(word_valid), 32'd0);
            if (cyc == 7) chk("p4_addr", 32'(address_rom), 32'h0020);
            if (cyc == 9) chk("p4_first", 32'(word_valid), 32'd1);
            tick();
        end
        redirect_valid = 1'b0;
        word_ready     = 1'b0;
        chk("p4_drained", 32'(exp_q.size()), 32'd0);

        // Redirect to 0xFFFE, PC wraps to 0x0000
        word_ready = 1'b1;
        do_reset();
        push_exp(16'h0000);
        push_exp(16'h0001);
        push_exp(16'h0002);
        push_exp(16'hFFFE);
        push_exp(16'hFFFF);
        push_exp(16'h0000);
        push_exp(16'h0001);
        while (cyc < 11) begin
            redirect_valid = (cyc == 4);
            redirect_pc    = 16'hFFFE;
            at_mid();
            if (cyc == 5 || cyc == 6) chk("p5_gap", 32'(word_valid), 32'd0);
            if (cyc >= 7) chk("p5_valid", 32'(word_valid), 32'd1);
            tick();
        end
        redirect_valid = 1'b0;
        word_ready     = 1'b0;
        chk("p5_drained", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset pulse with three words buffered
        word_ready = 1'b0;
        do_reset();
        while (cyc < 4) tick();
        at_mid();
        chk("p6_count_pre", 32'(fifo_count), 32'd3);
        #2;
        reset_n = 1'b0;
        #1;
        chk("p6_async_valid", 32'(word_valid),  32'd0);
        chk("p6_async_count", 32'(fifo_count),  32'd0);
        chk("p6_async_addr",  32'(address_rom), 32'd0);
        @(posedge clock);
        #1;
        reset_n    = 1'b1;
        cyc        = 0;
        word_ready = 1'b1;
        for (int i = 0; i <= 3; i++) push_exp(16'(i));
        while (cyc < 6) begin
            at_mid();
            chk("p6_addr", 32'(address_rom), 32'(cyc));
            tick();
        end
        word_ready = 1'b0;
        chk("p6_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
